// File: rtl/quad_xor_self_test_ctrl_if.sv
// Signal bundle between the quad XOR self-test sequencer and its host / gate package.
// Handshake: start is a one-cycle request taken only while the sequencer is idle;
// busy rises on the following cycle, and done pulses once when the run has finished.
interface quad_xor_self_test_ctrl_if;
  logic       start;
  logic [3:0] y_in;
  logic [3:0] a_out;
  logic [3:0] b_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_mask;
  logic [1:0] first_fail_gate;
  logic [1:0] first_fail_vec;
  logic [2:0] dbg_state;

  modport slave (
    input  start, y_in,
    output a_out, b_out, busy, done, pass, fail_mask,
           first_fail_gate, first_fail_vec, dbg_state
  );

  modport master (
    output start, y_in,
    input  a_out, b_out, busy, done, pass, fail_mask,
           first_fail_gate, first_fail_vec, dbg_state
  );
endinterface

// File: rtl/quad_xor_self_test_ctrl.sv
// Self-test sequencer for a quad 2-input XOR: walks every gate through 00,01,10,11 and checks Y.
// Optional macro QUAD_XOR_STOP_ON_FAIL_EN ends the run at the first failing vector.
module quad_xor_self_test_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input logic                      clk,
  input logic                      reset,
  quad_xor_self_test_ctrl_if.slave io
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_g;
  logic [1:0]       r_v;
  logic [1:0]       w_g_next;
  logic [1:0]       w_v_next;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_a_out;
  logic [3:0]       r_b_out;
  logic [3:0]       r_fail_mask;
  logic             r_pass;
  logic [1:0]       r_first_fail_gate;
  logic [1:0]       r_first_fail_vec;
  logic [3:0]       w_exp;
  logic [3:0]       w_mis;
  logic             w_any_mis;
  logic             w_stop;

  // A bit whose value is not a clean match (including X/Z in simulation) takes the else branch.
  always_comb begin
    w_exp      = '0;
    w_exp[r_g] = r_v[1] ^ r_v[0];
    w_mis      = '0;
    for (int i = 0; i < 4; i++) begin
      if (io.y_in[i] == w_exp[i]) w_mis[i] = 1'b0;
      else                        w_mis[i] = 1'b1;
    end
    w_any_mis = |w_mis;
  end

  always_comb begin
    w_stop = 1'b0;
`ifdef QUAD_XOR_STOP_ON_FAIL_EN
    w_stop = w_any_mis;
`endif
  end

  always_comb begin
    w_state_next = r_state;
    w_g_next     = r_g;
    w_v_next     = r_v;
    unique case (r_state)
      S_IDLE: begin
        if (io.start) begin
          w_state_next = S_APPLY;
          w_g_next     = 2'd0;
          w_v_next     = 2'd0;
        end
      end
      S_APPLY: begin
        w_state_next = (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
      end
      S_SETTLE: begin
        if (r_cnt <= CNT_W'(1)) w_state_next = S_CHECK;
      end
      S_CHECK: begin
        if (w_stop) begin
          w_state_next = S_DONE;
        end else if (r_v != 2'd3) begin
          w_v_next     = r_v + 2'd1;
          w_state_next = S_APPLY;
        end else if (r_g != 2'd3) begin
          w_v_next     = 2'd0;
          w_g_next     = r_g + 2'd1;
          w_state_next = S_APPLY;
        end else begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= S_IDLE;
      r_g               <= 2'd0;
      r_v               <= 2'd0;
      r_cnt             <= '0;
      r_a_out           <= 4'd0;
      r_b_out           <= 4'd0;
      r_fail_mask       <= 4'd0;
      r_pass            <= 1'b0;
      r_first_fail_gate <= 2'd0;
      r_first_fail_vec  <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_g     <= w_g_next;
      r_v     <= w_v_next;

      if (r_state == S_APPLY)       r_cnt <= CNT_W'(SETTLE_CYCLES);
      else if (r_state == S_SETTLE) r_cnt <= r_cnt - 1'b1;

      // Drive is registered on the edge entering APPLY and held through SETTLE and CHECK.
      if (w_state_next == S_APPLY) begin
        r_a_out <= {3'b000, w_v_next[1]} << w_g_next;
        r_b_out <= {3'b000, w_v_next[0]} << w_g_next;
      end else if (w_state_next == S_DONE || w_state_next == S_IDLE) begin
        r_a_out <= 4'd0;
        r_b_out <= 4'd0;
      end

      if (r_state == S_IDLE && io.start) begin
        r_fail_mask       <= 4'd0;
        r_pass            <= 1'b0;
        r_first_fail_gate <= 2'd0;
        r_first_fail_vec  <= 2'd0;
      end

      if (r_state == S_CHECK) begin
        r_fail_mask <= r_fail_mask | w_mis;
        if (r_fail_mask == 4'd0 && w_any_mis) begin
          r_first_fail_gate <= r_g;
          r_first_fail_vec  <= r_v;
        end
        // Verdict includes the mismatch of this final CHECK so it is valid during done.
        if (w_state_next == S_DONE) r_pass <= ((r_fail_mask | w_mis) == 4'd0);
      end
    end
  end

  assign io.a_out           = r_a_out;
  assign io.b_out           = r_b_out;
  assign io.busy            = (r_state == S_APPLY) || (r_state == S_SETTLE) || (r_state == S_CHECK);
  assign io.done            = (r_state == S_DONE);
  assign io.pass            = r_pass;
  assign io.fail_mask       = r_fail_mask;
  assign io.first_fail_gate = r_first_fail_gate;
  assign io.first_fail_vec  = r_first_fail_vec;
  assign io.dbg_state       = r_state;

endmodule

// File: tb/tb_quad_xor_self_test_ctrl.sv
// Bench for quad_xor_self_test_ctrl: modelled gate package with injectable faults,
// reference model per run, and a monitor that checks drive patterns and results.
module tb_quad_xor_self_test_ctrl;
  localparam int S       = 2;
  localparam int VEC_CYC = S + 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  quad_xor_self_test_ctrl_if bus ();

  quad_xor_self_test_ctrl #(.SETTLE_CYCLES(S), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int f_mode = 0;
  int f_k    = 0;
  int f_vv   = 0;

  // Expected run result: {len[9:0], pass, fail_mask[3:0], first_gate[1:0], first_vec[1:0]}
  logic [18:0] exp_q[$];

  // Gate package model: 1 gate3 stuck-at-0, 2 gate1 is an AND, 3 Y2 shorted to Y1,
  // 4 gate k output inverted whenever its inputs equal vv.
  function automatic logic [3:0] part_model(logic [3:0] a, logic [3:0] b, int mode, int k, int vv);
    logic [3:0] y;
    y = a ^ b;
    case (mode)
      1: y[2] = 1'b0;
      2: y[0] = a[0] & b[0];
      3: y[1] = y[0];
      4: if ({a[k], b[k]} == 2'(vv)) y[k] = ~y[k];
      default: ;
    endcase
    return y;
  endfunction

  assign bus.y_in = part_model(bus.a_out, bus.b_out, f_mode, f_k, f_vv);

  function automatic logic [18:0] ref_run(int mode, int k, int vv);
    logic [3:0] mask, a, b, y, e, mis;
    logic [1:0] fg, fv;
    int n_vec;
    mask  = 4'd0;
    fg    = 2'd0;
    fv    = 2'd0;
    n_vec = 16;
    for (int idx = 0; idx < 16; idx++) begin
      int g, v;
      g = idx / 4;
      v = idx % 4;
      a = 4'd0;
      b = 4'd0;
      a[g] = v[1];
      b[g] = v[0];
      e = 4'd0;
      e[g] = a[g] ^ b[g];
      y = part_model(a, b, mode, k, vv);
      mis = y ^ e;
      if (mis != 4'd0 && mask == 4'd0) begin
        fg = 2'(g);
        fv = 2'(v);
      end
      mask = mask | mis;
`ifdef QUAD_XOR_STOP_ON_FAIL_EN
      if (mis != 4'd0) begin
        n_vec = idx + 1;
        break;
      end
`endif
    end
    return {10'(n_vec * VEC_CYC), (mask == 4'd0), mask, fg, fv};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: drive schedule during busy, result fields on done, done pulse width.
  int   run_cyc = 0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      run_cyc   = 0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) chk("done_width", 32'(bus.done), 32'd0);
      if (bus.busy) begin
        int idx, g, v;
        logic [3:0] ea, eb;
        idx = run_cyc / VEC_CYC;
        g   = (idx / 4) % 4;
        v   = idx % 4;
        ea  = v[1] ? (4'b0001 << g) : 4'b0000;
        eb  = v[0] ? (4'b0001 << g) : 4'b0000;
        chk("a_out_sched", 32'(bus.a_out), 32'(ea));
        chk("b_out_sched", 32'(bus.b_out), 32'(eb));
        run_cyc++;
      end else if (bus.done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          logic [18:0] e;
          e = exp_q.pop_front();
          chk("busy_len",        32'(run_cyc),             32'(e[18:9]));
          chk("pass",            32'(bus.pass),            32'(e[8]));
          chk("fail_mask",       32'(bus.fail_mask),       32'(e[7:4]));
          chk("first_fail_gate", 32'(bus.first_fail_gate), 32'(e[3:2]));
          chk("first_fail_vec",  32'(bus.first_fail_vec),  32'(e[1:0]));
          chk("done_a_out",      32'(bus.a_out),           32'd0);
          chk("done_b_out",      32'(bus.b_out),           32'd0);
        end
        n_done++;
        run_cyc = 0;
      end else begin
        run_cyc = 0;
      end
      prev_done = bus.done;
    end
  end

  logic [18:0] last_exp;

  task automatic start_run(input int mode, input int k, input int vv);
    f_mode   = mode;
    f_k      = k;
    f_vv     = vv;
    last_exp = ref_run(mode, k, vv);
    exp_q.push_back(last_exp);
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic poke_start(input int cycles);
    repeat (cycles) @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int seen;
    seen = n_done;
    for (int c = 0; c < budget && n_done == seen; c++) @(posedge clk);
    if (n_done == seen) chk("done_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_hold();
    repeat (3) @(negedge clk);
    chk("pass_hold",      32'(bus.pass),      32'(last_exp[8]));
    chk("fail_mask_hold", 32'(bus.fail_mask), 32'(last_exp[7:4]));
    chk("idle_busy",      32'(bus.busy),      32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy",  32'(bus.busy),            32'd0);
    chk("rst_done",  32'(bus.done),            32'd0);
    chk("rst_pass",  32'(bus.pass),            32'd0);
    chk("rst_mask",  32'(bus.fail_mask),       32'd0);
    chk("rst_gate",  32'(bus.first_fail_gate), 32'd0);
    chk("rst_vec",   32'(bus.first_fail_vec),  32'd0);
    chk("rst_a_out", 32'(bus.a_out),           32'd0);
    chk("rst_b_out", 32'(bus.b_out),           32'd0);

    // Directed: good part, stuck-at gate 3, AND in gate 1, Y2/Y1 short.
    for (int m = 0; m < 4; m++) begin
      start_run(m, 0, 0);
      wait_done(2000);
      check_hold();
    end

    // Reset in the middle of a run aborts it with no done pulse.
    start_run(0, 0, 0);
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    chk("abort_busy",  32'(bus.busy),  32'd0);
    chk("abort_a_out", 32'(bus.a_out), 32'd0);
    chk("abort_b_out", 32'(bus.b_out), 32'd0);
    chk("abort_pass",  32'(bus.pass),  32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(bus.done), 32'd0);
    end

    start_run(0, 0, 0);
    wait_done(2000);
    check_hold();

    // Start pulse mid-run must not disturb the run.
    start_run(2, 0, 0);
    poke_start(30 % int'(last_exp[18:9]) + 1);
    wait_done(2000);
    check_hold();

    // Randomized faults, gaps and stray start pulses.
    for (int r = 0; r < 14; r++) begin
      int mode, len;
      mode = $urandom_range(0, 4);
      start_run(mode, $urandom_range(0, 3), $urandom_range(0, 3));
      len = int'(last_exp[18:9]);
      if (len > 3 && $urandom_range(0, 1) == 1) poke_start($urandom_range(1, len - 2));
      wait_done(2000);
      check_hold();
      repeat ($urandom_range(0, 5)) @(posedge clk);
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
